// File: rtl/arm32_fetch_stage.sv
// ARM32 instruction fetch: PC, credit-limited imem requests, in-order prefetch FIFO, branch flush.
// Optional define ARM32_FETCH_ALIGN_CHECK_EN adds a sticky misaligned-branch-target fault.
module arm32_fetch_stage #(
    parameter int             N          = 32,
    parameter logic [N-1:0]   RESET_PC   = '0,
    parameter int             FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [N-1:0] imem_rdata,
    output logic         if_valid,
    output logic [N-1:0] if_ins,
    output logic [N-1:0] if_pc,
    input  logic         id_ready,
    input  logic         br_taken,
    input  logic [N-1:0] br_target,
    output logic         fetch_fault
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [N-1:0]  pc;
    logic [CW-1:0] outstanding, drop, count;
    logic [PW-1:0] wr_ptr, rd_ptr, sh_wr, sh_rd;
    logic [N-1:0]  ins_mem [FIFO_DEPTH];
    logic [N-1:0]  pc_mem  [FIFO_DEPTH];
    logic [N-1:0]  sh_mem  [FIFO_DEPTH];

    logic          accept, push, pop, discard;
    logic [CW:0]   in_use;

    // A same-cycle dequeue frees a slot, which keeps 1 instr/cycle with a 2-deep FIFO.
    always_comb begin
        pop      = (count != '0) && id_ready && !br_taken;
        in_use   = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
        imem_req = reset_n && !br_taken && (in_use < (CW+1)'(FIFO_DEPTH));
        accept   = imem_req && imem_ready;
        discard  = imem_rvalid && (drop != '0);
        push     = imem_rvalid && (drop == '0) && !br_taken;
    end

    assign imem_addr = pc;
    assign if_valid  = (count != '0);
    assign if_ins    = if_valid ? ins_mem[rd_ptr] : '0;
    assign if_pc     = if_valid ? pc_mem[rd_ptr]  : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sh_wr       <= '0;
            sh_rd       <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(imem_rvalid);
            if (accept) begin
                pc    <= pc + N'(4);
                sh_wr <= sh_wr + PW'(1);
            end
            if (imem_rvalid)
                sh_rd <= sh_rd + PW'(1);
            // Everything still in flight is stale once a branch is taken.
            if (br_taken) begin
                pc     <= {br_target[N-1:2], 2'b00};
                drop   <= outstanding - CW'(imem_rvalid);
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (discard)
                    drop <= drop - CW'(1);
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            sh_mem[sh_wr] <= pc;
        if (push) begin
            ins_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]  <= sh_mem[sh_rd];
        end
    end

`ifdef ARM32_FETCH_ALIGN_CHECK_EN
    logic fault_q;
    always_ff @(posedge clk) begin
        if (!reset_n)
            fault_q <= 1'b0;
        else if (br_taken && (br_target[1:0] != 2'b00))
            fault_q <= 1'b1;
    end
    assign fetch_fault = fault_q;
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^br_target[1:0];
    assign fetch_fault    = 1'b0;
`endif
endmodule

// File: tb/tb_arm32_fetch_stage.sv
// Directed bench for arm32_fetch_stage: memory model with configurable latency and
// a scoreboard of expected {pc, ins} deliveries built from the bench's own fetch-PC model.
module tb_arm32_fetch_stage;
    logic        clk, reset_n;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, id_ready, br_taken, fetch_fault;
    logic [31:0] if_ins, if_pc, br_target;

    arm32_fetch_stage dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc), .id_ready(id_ready),
        .br_taken(br_taken), .br_target(br_target), .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] dlv[$];
    logic [31:0] acc[$];
    logic [31:0] exp_pc;
    int          cyc = 0;
    int          lat = 1;
    int          checks = 0;
    int          errors = 0;
    logic        s_req, s_valid;
    logic [31:0] s_pc;

`ifdef ARM32_FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] FAULT_EXP = 32'd1;
`else
    localparam logic [31:0] FAULT_EXP = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the edge, sample and score at the falling edge.
    task automatic step(input logic br, input logic [31:0] tgt, input logic idr, input logic rdy);
        logic [31:0] e;
        @(posedge clk); #1;
        cyc++;
        br_taken   = br;
        br_target  = tgt;
        id_ready   = idr;
        imem_ready = rdy;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].addr + 32'd1;
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'd0;
        end
        @(negedge clk);
        s_req   = imem_req;
        s_valid = if_valid;
        s_pc    = if_pc;
        if (br) begin
            check("br_no_req", {31'd0, imem_req}, 32'd0);
            exp_q.delete();
            exp_pc = {tgt[31:2], 2'b00};
        end else begin
            if (if_valid && id_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("if_pc", if_pc, e);
                check("if_ins", if_ins, e + 32'd1);
                dlv.push_back(if_pc);
            end
            if (imem_req && imem_ready) begin
                check("imem_addr", imem_addr, exp_pc);
                mq.push_back('{imem_addr, cyc + lat});
                acc.push_back(imem_addr);
                exp_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        cyc++;
        reset_n     = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'd0;
        id_ready    = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        @(posedge clk); #1;
        cyc++;
        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_ins", if_ins, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        mq.delete();
        exp_q.delete();
        dlv.delete();
        acc.delete();
        exp_pc  = 32'd0;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1; br_taken = 1'b0; br_target = 32'd0; id_ready = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

        // Streaming from reset with 1-cycle memory
        do_reset();
        lat = 1;
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t1_first_req", {31'd0, s_req}, 32'd1);
        check("t1_valid_c1", {31'd0, s_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t1_valid_c2", {31'd0, s_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t1_valid_c3", {31'd0, s_valid}, 32'd1);
        repeat (5) step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t1_throughput", 32'(dlv.size()), 32'd6);
        check("t1_third_pc", dlv[2], 32'h8);

        // Decode stalled for 5 cycles
        do_reset();
        repeat (5) step(1'b0, 32'd0, 1'b0, 1'b1);
        check("t2_num_req", 32'(acc.size()), 32'd2);
        check("t2_req_low", {31'd0, s_req}, 32'd0);
        check("t2_valid", {31'd0, s_valid}, 32'd1);
        check("t2_pc_held", s_pc, 32'h0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t2_dlv_cnt", 32'(dlv.size()), 32'd2);
        check("t2_dlv0", dlv[0], 32'h0);
        check("t2_dlv1", dlv[1], 32'h4);

        // Branch with two requests in flight (3-cycle memory)
        do_reset();
        lat = 3;
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t3_inflight", 32'(acc.size()), 32'd2);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        dlv.delete();
        repeat (10) step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t3_dlv0", dlv[0], 32'h100);
        check("t3_dlv1", dlv[1], 32'h104);

        // Branch coinciding with a response and a decode handshake
        do_reset();
        lat = 1;
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b1, 32'h40, 1'b1, 1'b1);
        check("t4_valid_at_br", {31'd0, s_valid}, 32'd1);
        check("t4_rvalid_at_br", {31'd0, imem_rvalid}, 32'd1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t4_valid_t1", {31'd0, s_valid}, 32'd0);
        check("t4_req_t1", {31'd0, s_req}, 32'd1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t4_valid_t2", {31'd0, s_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t4_valid_t3", {31'd0, s_valid}, 32'd1);
        check("t4_pc_t3", s_pc, 32'h40);

        // Memory back-pressure, then address wrap-around
        do_reset();
        step(1'b0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            check("t5_stall_req", {31'd0, imem_req}, 32'd1);
            check("t5_stall_addr", imem_addr, 32'h8);
        end
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t5_dlv_order", dlv[2], 32'h8);
        acc.delete();
        dlv.delete();
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        repeat (6) step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t5_acc0", acc[0], 32'hFFFF_FFF8);
        check("t5_acc1", acc[1], 32'hFFFF_FFFC);
        check("t5_acc_wrap", acc[2], 32'h0);
        check("t5_dlv_wrap", dlv[2], 32'h0);

        // Misaligned branch target
        check("t6_fault_pre", {31'd0, fetch_fault}, 32'd0);
        acc.delete();
        dlv.delete();
        step(1'b1, 32'h202, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t6_fault", {31'd0, fetch_fault}, FAULT_EXP);
        repeat (5) step(1'b0, 32'd0, 1'b1, 1'b1);
        check("t6_fault_sticky", {31'd0, fetch_fault}, FAULT_EXP);
        check("t6_aligned_addr", acc[0], 32'h200);
        check("t6_aligned_pc", dlv[0], 32'h200);

        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arm32_fetch_stage.md
# arm32_fetch_stage

Instruction fetch stage of the ARM32 core. It owns the program counter and issues word reads to instruction memory. Returned instruction words are buffered in a small in-order prefetch FIFO, and each buffered word is presented with its PC to the decode stage through a valid/ready handshake. Taken branches from execute redirect the PC and flush all in-flight and buffered instructions.

## Interface
Parameters:
- N, 32, data/address width.
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- FIFO_DEPTH, 2, prefetch FIFO entries. Power of two, at least 2. Also the cap on requests in flight plus entries held.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  read request; memory accepts it when imem_ready is high in the same cycle.
- imem_addr  out  N  byte address of the request; always word aligned.
- imem_ready  in  1  memory can accept a request this cycle.
- imem_rvalid  in  1  read data valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rdata  in  N  instruction word.
- if_valid  out  1  if_ins/if_pc hold a valid instruction.
- if_ins  out  N  instruction word to decode.
- if_pc  out  N  byte address of if_ins.
- id_ready  in  1  decode consumes the instruction when if_valid and id_ready are both high.
- br_taken  in  1  redirect request from execute.
- br_target  in  N  branch target byte address.
- fetch_fault  out  1  misaligned branch target (only with ARM32_FETCH_ALIGN_CHECK_EN).

## Operation
- State:
  - pc: next fetch address.
  - outstanding: accepted requests not yet answered, width clog2(FIFO_DEPTH)+1.
  - drop: responses still to be discarded, same width.
  - FIFO holding {ins, pc} pairs, with pointers and a count.
- Request issue:
  - imem_req = !br_taken && (outstanding + count) < FIFO_DEPTH.
  - Credits count a same-cycle dequeue.
  - On acceptance (imem_req && imem_ready): pc <= pc + 4 with 32-bit wrap-around (32'hFFFF_FFFC wraps to 0); outstanding increments.
  - imem_addr = pc.
- Response:
  - imem_rvalid decrements outstanding.
  - If drop > 0, the data is discarded and drop decrements.
  - Otherwise {imem_rdata, address of that request} is written to the FIFO. A shadow address FIFO tracks in-flight request PCs.
  - A response can never arrive with the FIFO full; the credit rule guarantees this.
- Dequeue:
  - if_valid = count != 0. if_ins and if_pc come from the FIFO head.
  - The head pops on if_valid && id_ready.
- Branch redirect (br_taken high in cycle t):
  - At the edge ending cycle t: pc <= {br_target[N-1:2], 2'b00}, FIFO cleared, drop <= outstanding minus any response arriving in cycle t.
  - Any response in cycle t is discarded.
  - No request is issued in cycle t.
  - The branch wins over a simultaneous dequeue or enqueue. Decode must ignore a handshake in cycle t; the pop has no effect.
- Back-to-back branches: the second branch recomputes drop and its target takes effect.
- Responses still owed to dropped requests never reach decode. outstanding still tracks them for credit.
- If imem_ready is low, imem_req stays high with imem_addr stable.

## Timing
- Reset values:
  - imem_req 0, imem_addr RESET_PC, if_valid 0, if_ins 0, if_pc 0, fetch_fault 0.
  - pc RESET_PC; outstanding, drop, count all 0.
- Reset applied mid-operation discards everything. Late responses arriving after reset release are not tracked and are a memory-side error; the bench must not issue them.
- First request is in the first cycle after reset_n rises.
- Latency:
  - Request accepted in cycle t, rvalid in cycle t+1 → if_valid in cycle t+2.
  - Sustained throughput is 1 instruction/cycle with FIFO_DEPTH ≥ 2 and 1-cycle memory.
- Branch in cycle t:
  - if_valid is 0 in cycle t+1.
  - First target request goes out in cycle t+1.
  - With 1-cycle memory, the target instruction is valid in cycle t+3.

## Configuration
- ARM32_FETCH_ALIGN_CHECK_EN defined:
  - A taken branch with br_target[1:0] != 0 sets fetch_fault at the edge ending the branch cycle.
  - The redirect and flush still occur; fetching proceeds from the aligned address.
  - fetch_fault is sticky until reset.
- Not defined: fetch_fault is tied to 0 and targets are silently aligned.

## Test plan
- Reset release, 1-cycle memory returning mem[addr>>2] = addr+1, id_ready=1:
  - Requests go to 0x0, 0x4, 0x8, …
  - if_valid first high 2 cycles after the first request.
  - Outputs if_pc/if_ins = 0x0/0x1, 0x4/0x5, 0x8/0x9 on consecutive cycles.
- id_ready held 0 for 5 cycles:
  - At most 2 requests issued, then imem_req low.
  - if_pc held at 0x0.
  - On release, 0x0 then 0x4 are delivered with no loss or duplicate.
- br_taken with br_target=0x100 while 2 requests are in flight:
  - Both stale responses are dropped.
  - The next delivered if_pc is 0x100, then 0x104.
- Branch in the same cycle as a response and an id_ready pop:
  - The response is discarded; count becomes 0.
  - Next if_pc equals the branch target.
- imem_ready low for 3 cycles: imem_addr stays stable at 0x8 and if_pc order is unchanged. Separately, fetch starting at 0xFFFF_FFF8 issues 0xFFFF_FFFC then wraps to 0x0.
- ARM32_FETCH_ALIGN_CHECK_EN defined, br_target=0x202:
  - fetch_fault goes to 1 and stays 1.
  - Fetch resumes at 0x200.
- Macro undefined: fetch_fault remains 0.
